uart_tx_fifo_param: RTL and testbench
=====================================

Name: uart_tx_fifo_param

Overview:
Parametrised successor to the CoreUARTapb fixed-format transmitter. It provides:
- runtime-selectable character length (5..DATA_W), parity mode and 1/2 stop bits;
- an integrated FIFO with a valid/ready write port;
- back-to-back frames with no idle gap.

It sits between the APB register block (or any streaming source) and the TX pin. Bit timing comes from the shared external baud generator, as a one-clk tick per bit time.

Parameters:
- DATA_W, 8, maximum character width; legal 5..9.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >=2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the level counter. Derived; not overridden by users.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- baud_tick  in  1  one-clk pulse per bit period.
- char_len  in  4  data bits per frame. Values <5 treated as 5; values >DATA_W treated as DATA_W.
- parity_mode  in  3  000 none, 001 odd, 010 even, 011 mark, 100 space; 101-111 = none.
- stop2  in  1  1 = two stop bits.
- in_data  in  DATA_W  character to send, LSB first.
- in_valid  in  1  source has data.
- in_ready  out  1  FIFO can accept; equals !full.
- tx  out  1  serial output, idle high.
- busy  out  1  high when state != IDLE or FIFO is non-empty.
- tx_done  out  1  one-clk pulse at the end of each frame's last stop bit.
- fifo_level  out  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): tx=1, state=IDLE, FIFO empty, fifo_level=0, in_ready=1, busy=0, tx_done=0. Asserting reset mid-frame aborts the frame, drives tx high immediately and discards the FIFO contents.
- Write: push occurs when in_valid & in_ready at a clk edge. fifo_level updates on the next edge.
- FIFO: registered, not fall-through.
  - Push into an empty FIFO: the entry is poppable at the earliest on the following cycle.
  - Push and pop in the same cycle: level unchanged.
  - A push is never accepted while full.
  - Pointers wrap modulo FIFO_DEPTH.
- Shift register width is DATA_W. char_len, parity_mode and stop2 are latched at pop and held for the whole frame; changes mid-frame affect only later frames.
- States: IDLE, LOAD, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: tx=1. If the FIFO is non-empty, pop and go to LOAD. This transition is clk-paced, not tick-paced.
  - LOAD: tx=1. On baud_tick, go to START.
  - START: tx=0 is registered on the same edge that enters START. On baud_tick, go to DATA with tx=d[0].
  - DATA: the bit index increments on each tick. After bit char_len-1 has been driven for one tick, go to PARITY if parity is enabled, else STOP1.
  - PARITY: tx is the parity bit.
    - odd: tx = ~^data
    - even: tx = ^data
    - mark: tx = 1
    - space: tx = 0
    - Computed over only the char_len latched bits.
  - STOP1: tx=1. On tick, go to STOP2 if stop2 is latched, else end of frame.
  - STOP2: tx=1. On tick, end of frame.
- End of frame (on the final tick):
  - tx_done=1 for one clk.
  - If the FIFO is non-empty: pop, latch the new config, and go directly to START with tx=0. Zero idle gap.
  - Otherwise: go to IDLE.
- Every bit lasts exactly one tick interval. Frame length in ticks = 1 + char_len + (parity?1:0) + (stop2?2:1).
- baud_tick in IDLE is ignored. A tick coincident with a pop in IDLE is also ignored; that frame starts on the next tick.
- Unused upper shift-register bits are never driven to tx.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- When defined:
  - Adds input port cts_n (1 bit, active-low clear-to-send, asynchronous). It is 2-flop synchronised to clk, reset value 1 (not clear).
  - A pop, from IDLE or at end of frame, is allowed only while synchronised cts_n==0. Otherwise the block stays/returns in IDLE with tx=1.
  - cts_n deasserting mid-frame never aborts the current frame.
- When undefined: the port is absent and pops are always permitted.

Test Plan:
- 8N1, DATA_W=8, write 0xA5 with ticks every 16 clk. Required tx sequence per tick: 0,1,0,1,0,0,1,0,1,1. Then tx_done pulses once and busy falls.
- char_len=7, even parity, stop2=1, send 0x53 (bits 1010011, four ones). Required tx: 0,1,1,0,0,1,0,1,0(parity),1,1. Frame is 11 ticks.
- Push 3 bytes 0x01,0x02,0x03 back-to-back, 8N1. Required: no idle-high gap between frames; STOP of one frame is followed immediately by START of the next; 3 tx_done pulses; total 30 ticks.
- FIFO_DEPTH=4 with no ticks, hold in_valid high for 6 cycles. Required: first byte pops into LOAD; 4 more are accepted; in_ready=0 and fifo_level=4; remaining writes are held off.
- Assert reset mid-DATA state. Required: tx=1 within the reset cycle, fifo_level=0, in_ready=1, busy=0. After release, a new byte 0x3C transmits correctly.
- UART_TX_CTS_EN defined: cts_n=1, write 0x55. Required: no start bit for 100 ticks, busy=1. Drop cts_n: frame begins within 3 clk + 1 tick. Raising cts_n mid-frame: frame completes.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with an integrated TX FIFO and runtime character length, parity and stop bits.
// Optional feature macro UART_TX_CTS_EN adds a synchronised cts_n input that gates frame starts.
`timescale 1ns/1ps
module uart_tx_fifo_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_tick,
    input  logic [3:0]        char_len,
    input  logic [2:0]        parity_mode,
    input  logic              stop2,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
`ifdef UART_TX_CTS_EN
    input  logic              cts_n,
`endif
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [CNT_W-1:0]  fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t            state, state_d;
    logic              tx_d, done_d, pop, pop_ok, push, empty, full, frame_end;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  level;
    logic [DATA_W-1:0] head, mask, shreg;
    logic [3:0]        len_in, len_q, bit_idx;
    logic              par_en_in, par_bit_in, par_en_q, par_bit_q, stop2_q;

    assign full       = (level == CNT_W'(FIFO_DEPTH));
    assign empty      = (level == '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign fifo_level = level;
    assign head       = mem[rd_ptr];
    assign busy       = (state != IDLE) || !empty;

    // NOTE: the storage array has no reset; the pointers and level alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cts_sync <= 2'b11;
        else       cts_sync <= {cts_sync[0], cts_n};
    end
    assign pop_ok = !empty && !cts_sync[1];
`else
    assign pop_ok = !empty;
`endif

    // Frame format of the head entry, captured only when it is popped.
    always_comb begin
        len_in = char_len;
        if (char_len < 4'd5)              len_in = 4'd5;
        else if (char_len > 4'(DATA_W))   len_in = 4'(DATA_W);
        mask       = DATA_W'((1 << len_in) - 1);
        par_en_in  = parity_mode inside {3'b001, 3'b010, 3'b011, 3'b100};
        case (parity_mode)
            3'b001:  par_bit_in = ~^(head & mask);
            3'b010:  par_bit_in = ^(head & mask);
            3'b011:  par_bit_in = 1'b1;
            default: par_bit_in = 1'b0;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state;
        tx_d      = tx;
        pop       = 1'b0;
        done_d    = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (pop_ok) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: if (baud_tick) begin
                state_d = START;
                tx_d    = 1'b0;
            end
            START: if (baud_tick) begin
                state_d = DATA;
                tx_d    = shreg[0];
            end
            DATA: if (baud_tick) begin
                if (bit_idx == len_q - 4'd1) begin
                    state_d = par_en_q ? PARITY : STOP1;
                    tx_d    = par_en_q ? par_bit_q : 1'b1;
                end else begin
                    tx_d = shreg[0];
                end
            end
            PARITY: if (baud_tick) begin
                state_d = STOP1;
                tx_d    = 1'b1;
            end
            STOP1: if (baud_tick) begin
                if (stop2_q) state_d = STOP2;
                else         frame_end = 1'b1;
            end
            STOP2: if (baud_tick) frame_end = 1'b1;
            default: state_d = IDLE;
        endcase
        if (frame_end) begin
            done_d = 1'b1;
            if (pop_ok) begin
                pop     = 1'b1;
                state_d = START;
                tx_d    = 1'b0;
            end else begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_d;
            tx      <= tx_d;
            tx_done <= done_d;
        end
    end

    // Upper bits are masked off at pop, so only char_len bits ever shift out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bit_idx   <= '0;
            len_q     <= 4'(DATA_W);
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else if (pop) begin
            shreg     <= head & mask;
            bit_idx   <= '0;
            len_q     <= len_in;
            par_en_q  <= par_en_in;
            par_bit_q <= par_bit_in;
            stop2_q   <= stop2;
        end else if (baud_tick && state == START) begin
            shreg <= shreg >> 1;
        end else if (baud_tick && state == DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 4'd1;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Self-checking bench for uart_tx_fifo_param: frame vectors, back-to-back frames, FIFO fill, reset abort.
// With UART_TX_CTS_EN defined, the clear-to-send gating sequence also runs.
`timescale 1ns/1ps
module tb_uart_tx_fifo_param;
    logic       clk, reset, baud_tick, stop2, in_valid;
    logic [3:0] char_len;
    logic [2:0] parity_mode;
    logic [7:0] in_data;
    logic       in_ready, tx, busy, tx_done;
    logic [2:0] fifo_level;
`ifdef UART_TX_CTS_EN
    logic       cts_n;
`endif

    uart_tx_fifo_param #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .char_len(char_len),
        .parity_mode(parity_mode), .stop2(stop2), .in_data(in_data), .in_valid(in_valid),
`ifdef UART_TX_CTS_EN
        .cts_n(cts_n),
`endif
        .in_ready(in_ready), .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_level(fifo_level)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic [2:0] pmode;
        logic       s2;
        string      frame;   // expected tx level for each bit time, in transmission order
    } vec_t;

    int    checks = 0, failures = 0;
    int    tick_no = 0, last_done_tick = 0, frames_done = 0, done_pulses = 0, pos = 0;
    bit    in_frame = 1'b0, done_due = 1'b0, tick_en = 1'b0;
    string exp_q[$];
    string cur;
    int    starts[$];
    vec_t  vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic [3:0] l, input logic [2:0] p,
                                input logic s, input string f);
        vec_t v;
        v.data = d; v.len = l; v.pmode = p; v.s2 = s; v.frame = f;
        return v;
    endfunction

    function automatic string make_8n1(input logic [7:0] d);
        string s;
        s = "0";
        for (int i = 0; i < 8; i++) begin
            if (d[i]) s = {s, "1"};
            else      s = {s, "0"};
        end
        return {s, "1"};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) baud_tick = ((tick_no_gen() % 16) == 15);
            else         baud_tick = 1'b0;
        end
    end

    int gen_cnt = 0;
    function automatic int tick_no_gen();
        gen_cnt++;
        return gen_cnt;
    endfunction

    // Receiver model: sample tx just after every tick edge and match it against queued frames.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                in_frame = 1'b0;
                done_due = 1'b0;
            end else if (baud_tick) begin
                #1;
                tick_no++;
                if (done_due) begin
                    check("tx_done_at_frame_end", tx_done, 1'b1);
                    done_due       = 1'b0;
                    last_done_tick = tick_no;
                end
                if (!in_frame && tx == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_start_bit", tx, 1'b1);
                    end else begin
                        cur      = exp_q.pop_front();
                        pos      = 0;
                        in_frame = 1'b1;
                        starts.push_back(tick_no);
                    end
                end
                if (in_frame) begin
                    check($sformatf("tx_bit%0d", pos), tx, (cur[pos] == "1"));
                    pos++;
                    if (pos == cur.len()) begin
                        in_frame = 1'b0;
                        done_due = 1'b1;
                        frames_done++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tx_done === 1'b1) done_pulses++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", failures);
        $fatal(1, "watchdog");
    end

    task automatic write_byte(input logic [7:0] d, input string frame, input string name);
        bit accepted = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !accepted; i++) begin
            accepted = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({name, "_accepted"}, accepted, 1'b1);
        if (accepted) exp_q.push_back(frame);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (!(frames_done >= target && !done_due && !in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_in_time"}, (n < budget), 1'b1);
    endtask

    initial begin
        int tgt, pulses0, s0;
        bit exp_rdy[6];
        int exp_lvl[6];

        vecs[0] = mk(8'hA5, 4'd8,  3'd0, 1'b0, "0101001011");
        vecs[1] = mk(8'h53, 4'd7,  3'd2, 1'b1, "01100101011");
        vecs[2] = mk(8'h53, 4'd7,  3'd1, 1'b0, "0110010111");
        vecs[3] = mk(8'hE0, 4'd3,  3'd3, 1'b0, "00000011");
        vecs[4] = mk(8'h0F, 4'd15, 3'd4, 1'b1, "011110000011");
        vecs[5] = mk(8'h96, 4'd6,  3'd2, 1'b0, "001101011");
        vecs[6] = mk(8'h3C, 4'd5,  3'd7, 1'b0, "0001111");
        vecs[7] = mk(8'h01, 4'd8,  3'd1, 1'b1, "010000000011");
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_lvl = '{0, 1, 1, 2, 3, 4};

        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        char_len = 4'd8; parity_mode = 3'd0; stop2 = 1'b0;
`ifdef UART_TX_CTS_EN
        cts_n = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_level", fifo_level, 0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_tx_done", tx_done, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tick_en = 1'b1;

        // Single frames across formats; the format inputs are scrambled once the frame is under way.
        for (int i = 0; i < 8; i++) begin
            char_len = vecs[i].len; parity_mode = vecs[i].pmode; stop2 = vecs[i].s2;
            pulses0 = done_pulses;
            tgt     = frames_done + 1;
            write_byte(vecs[i].data, vecs[i].frame, $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
            char_len = 4'd5; parity_mode = 3'd3; stop2 = 1'b1;
            wait_frames(tgt, 600, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_done_pulses", i), done_pulses - pulses0, 1);
            check($sformatf("vec%0d_busy_low", i), busy, 1'b0);
        end

        // Three queued 8N1 bytes must go out with no idle bit time between frames.
        char_len = 4'd8; parity_mode = 3'd0; stop2 = 1'b0;
        s0 = starts.size(); pulses0 = done_pulses; tgt = frames_done + 3;
        write_byte(8'h01, make_8n1(8'h01), "b2b0");
        write_byte(8'h02, make_8n1(8'h02), "b2b1");
        write_byte(8'h03, make_8n1(8'h03), "b2b2");
        wait_frames(tgt, 1200, "b2b");
        check("b2b_done_pulses", done_pulses - pulses0, 3);
        check("b2b_starts", starts.size() - s0, 3);
        if (starts.size() - s0 == 3) begin
            check("b2b_gap01", starts[s0+1] - starts[s0], 10);
            check("b2b_gap12", starts[s0+2] - starts[s0+1], 10);
            check("b2b_total_ticks", last_done_tick - starts[s0], 30);
        end

        // FIFO fill with ticks stopped: one entry parks in LOAD, four more fill the FIFO.
        tick_en = 1'b0;
        repeat (3) @(negedge clk);
        tgt = frames_done + 5;
        for (int i = 0; i < 6; i++) begin
            in_data  = 8'h10 + 8'(i);
            in_valid = 1'b1;
            check($sformatf("fill%0d_in_ready", i), in_ready, exp_rdy[i]);
            check($sformatf("fill%0d_level", i), fifo_level, exp_lvl[i]);
            if (exp_rdy[i]) exp_q.push_back(make_8n1(8'h10 + 8'(i)));
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("fill_level_full", fifo_level, 4);
        check("fill_in_ready_low", in_ready, 1'b0);
        check("fill_busy", busy, 1'b1);
        check("fill_tx_idle", tx, 1'b1);
        tick_en = 1'b1;
        wait_frames(tgt, 1500, "fill_drain");
        check("fill_drained_level", fifo_level, 0);

        // Reset in the middle of a data bit aborts the frame and flushes the FIFO.
        write_byte(8'h00, make_8n1(8'h00), "rst_a");
        write_byte(8'h81, make_8n1(8'h81), "rst_b");
        begin
            int n = 0;
            while (!(in_frame && pos >= 3) && n < 600) begin
                @(negedge clk);
                n++;
            end
            check("rst_reach_data_in_time", (n < 600), 1'b1);
        end
        check("pre_reset_tx", tx, 1'b0);
        check("pre_reset_level", fifo_level, 1);
        reset = 1'b1;
        #1;
        check("mid_reset_tx", tx, 1'b1);
        check("mid_reset_level", fifo_level, 0);
        check("mid_reset_in_ready", in_ready, 1'b1);
        check("mid_reset_busy", busy, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tgt = frames_done + 1;
        write_byte(8'h3C, make_8n1(8'h3C), "after_reset");
        wait_frames(tgt, 600, "after_reset");
        check("after_reset_busy", busy, 1'b0);

`ifdef UART_TX_CTS_EN
        // Clear-to-send held off: the byte waits; releasing it starts the frame, raising it does not abort.
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        tgt = frames_done + 1;
        write_byte(8'h55, make_8n1(8'h55), "cts");
        s0 = tick_no;
        begin
            int n = 0;
            while (tick_no - s0 < 100 && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        check("cts_no_start", in_frame, 1'b0);
        check("cts_tx_idle", tx, 1'b1);
        check("cts_busy", busy, 1'b1);
        cts_n = 1'b0;
        begin
            int n = 0;
            while (!in_frame && n < 22) begin
                @(negedge clk);
                n++;
            end
            check("cts_start_latency", in_frame, 1'b1);
        end
        cts_n = 1'b1;
        wait_frames(tgt, 600, "cts_frame");
        check("cts_busy_after", busy, 1'b0);
`endif

        tick_en = 1'b0;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
